// File: rtl/reorder_buffer_pkg.sv
// Shared ROB widths and entry layout.
// The issue stage imports the same ID_SIZE so IDs stay aligned.
package reorder_buffer_pkg;

  localparam int REG_ADDRESS_SIZE = 5;
  localparam int REG_SIZE         = 32;
  localparam int ID_SIZE          = 2;
  localparam int DEPTH            = 1 << ID_SIZE;

  typedef logic [ID_SIZE-1:0]          rob_id_t;
  typedef logic [ID_SIZE:0]            rob_cnt_t;
  typedef logic [REG_ADDRESS_SIZE-1:0] reg_addr_t;
  typedef logic [REG_SIZE-1:0]         reg_data_t;

  typedef struct packed {
    logic      valid;
    logic      done;
    logic      w;
    reg_addr_t dest;
    reg_data_t value;
  } rob_entry_t;

  typedef struct packed {
    logic      valid;
    rob_id_t   id;
    reg_data_t value;
  } rob_result_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// ROB bus: issue allocation, unit results, flush, commit port.
// master = issue/units/register bank side, slave = ROB.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic      ROB_alloc;
  rob_id_t   ROB_alloc_id;
  reg_addr_t ROB_alloc_dest;
  logic      ROB_alloc_w;
  logic      ROB_alloc_done;

  logic      ROB_alu_valid;
  rob_id_t   ROB_alu_id;
  reg_data_t ROB_alu_value;

  logic      ROB_mul_valid;
  rob_id_t   ROB_mul_id;
  reg_data_t ROB_mul_value;

  logic      ROB_flush;

  reg_addr_t ROB_Wat;
  reg_data_t ROB_Wvalue;
  logic      ROB_We;
  logic      ROB_stall;
  rob_id_t   ROB_head;
  rob_cnt_t  ROB_count;

  modport master (
    output ROB_alloc, ROB_alloc_id, ROB_alloc_dest,
    output ROB_alloc_w, ROB_alloc_done,
    output ROB_alu_valid, ROB_alu_id, ROB_alu_value,
    output ROB_mul_valid, ROB_mul_id, ROB_mul_value,
    output ROB_flush,
    input  ROB_Wat, ROB_Wvalue, ROB_We,
    input  ROB_stall, ROB_head, ROB_count
  );

  modport slave (
    input  ROB_alloc, ROB_alloc_id, ROB_alloc_dest,
    input  ROB_alloc_w, ROB_alloc_done,
    input  ROB_alu_valid, ROB_alu_id, ROB_alu_value,
    input  ROB_mul_valid, ROB_mul_id, ROB_mul_value,
    input  ROB_flush,
    output ROB_Wat, ROB_Wvalue, ROB_We,
    output ROB_stall, ROB_head, ROB_count
  );

endinterface

// File: rtl/rob_entry_array.sv
// ROB storage: one alloc port, two completion ports,
// one read port at head; flush clears every entry.
module rob_entry_array
  import reorder_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        alloc_en,
  input  rob_id_t     alloc_id,
  input  rob_entry_t  alloc_entry,
  input  rob_result_t alu,
  input  rob_result_t mul,
  input  logic        retire,
  input  rob_id_t     head,
  output rob_entry_t  head_entry
);

  rob_entry_t ent [DEPTH];

  // alloc beats retire/completion; ALU beats MUL
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        ent[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].done  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_en && alloc_id == rob_id_t'(i)) begin
          ent[i] <= alloc_entry;
        end else if (retire && head == rob_id_t'(i)) begin
          ent[i].valid <= 1'b0;
          ent[i].done  <= 1'b0;
        end else if (alu.valid && alu.id == rob_id_t'(i)
                     && ent[i].valid) begin
          ent[i].value <= alu.value;
          ent[i].done  <= 1'b1;
        end else if (mul.valid && mul.id == rob_id_t'(i)
                     && ent[i].valid) begin
          ent[i].value <= mul.value;
          ent[i].done  <= 1'b1;
        end
      end
    end
  end

  assign head_entry = ent[head];

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit buffer: head/count control, commit port,
// full back-pressure and flush realignment to the issue tail.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input logic             clk,
  input logic             reset,
  reorder_buffer_if.slave bus
);

  rob_id_t     head;
  rob_cnt_t    count;
  rob_entry_t  head_e;
  rob_entry_t  alloc_e;
  rob_result_t alu_r;
  rob_result_t mul_r;
  logic        stall;
  logic        alloc_ok;
  logic        commit;
  logic        retire;

  assign stall    = (count == rob_cnt_t'(DEPTH));
  assign alloc_ok = bus.ROB_alloc && !stall;
  assign commit   = head_e.valid && head_e.done;
  assign retire   = commit && !bus.ROB_flush;

  assign alloc_e = '{valid: 1'b1,
                     done:  bus.ROB_alloc_done,
                     w:     bus.ROB_alloc_w,
                     dest:  bus.ROB_alloc_dest,
                     value: '0};
  assign alu_r = '{valid: bus.ROB_alu_valid,
                   id:    bus.ROB_alu_id,
                   value: bus.ROB_alu_value};
  assign mul_r = '{valid: bus.ROB_mul_valid,
                   id:    bus.ROB_mul_id,
                   value: bus.ROB_mul_value};

  rob_entry_array u_array (
    .clk         (clk),
    .reset       (reset),
    .flush       (bus.ROB_flush),
    .alloc_en    (alloc_ok),
    .alloc_id    (bus.ROB_alloc_id),
    .alloc_entry (alloc_e),
    .alu         (alu_r),
    .mul         (mul_r),
    .retire      (retire),
    .head        (head),
    .head_entry  (head_e)
  );

  // flush jumps head to the tail the issue stage already holds
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      count <= '0;
    end else if (bus.ROB_flush) begin
      head  <= head + rob_id_t'(count);
      count <= '0;
    end else begin
      head  <= head + rob_id_t'(retire);
      count <= count + rob_cnt_t'(alloc_ok)
                     - rob_cnt_t'(retire);
    end
  end

  assign bus.ROB_We     = retire && head_e.w;
  assign bus.ROB_Wat    = commit ? head_e.dest : '0;
  assign bus.ROB_Wvalue = commit ? head_e.value : '0;
  assign bus.ROB_stall  = stall;
  assign bus.ROB_head   = head;
  assign bus.ROB_count  = count;

  a_alloc_stall: assert property (
    @(posedge clk) disable iff (!reset)
    !(bus.ROB_alloc && stall));

  a_alloc_id: assert property (
    @(posedge clk) disable iff (!reset)
    alloc_ok |-> bus.ROB_alloc_id == head + rob_id_t'(count));

  a_same_id: assert property (
    @(posedge clk) disable iff (!reset)
    !(bus.ROB_alu_valid && bus.ROB_mul_valid
      && bus.ROB_alu_id == bus.ROB_mul_id));

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: vector table, corner sequences,
// random legal traffic against a program-order queue model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reorder_buffer_if rif();

  reorder_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int   id;
    bit   w;
    int   dest;
    int   value;
    bit   done;
  } ment_t;

  ment_t mq[$];
  int    mhead = 0;

  typedef struct {
    bit al; int id; int dest; bit w; bit dn;
    bit av; int aid; int aval;
    bit mv; int mid; int mval;
    bit we; int wat; int wv; int cnt; int hd;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h",
               name, $time, act, exp);
    end
  endtask

  task automatic idle();
    rif.ROB_alloc      = 1'b0;
    rif.ROB_alloc_id   = '0;
    rif.ROB_alloc_dest = '0;
    rif.ROB_alloc_w    = 1'b0;
    rif.ROB_alloc_done = 1'b0;
    rif.ROB_alu_valid  = 1'b0;
    rif.ROB_alu_id     = '0;
    rif.ROB_alu_value  = '0;
    rif.ROB_mul_valid  = 1'b0;
    rif.ROB_mul_id     = '0;
    rif.ROB_mul_value  = '0;
    rif.ROB_flush      = 1'b0;
  endtask

  task automatic set_alloc(int id, int dest, bit w, bit dn);
    rif.ROB_alloc      = 1'b1;
    rif.ROB_alloc_id   = rob_id_t'(id);
    rif.ROB_alloc_dest = reg_addr_t'(dest);
    rif.ROB_alloc_w    = w;
    rif.ROB_alloc_done = dn;
  endtask

  task automatic set_alu(int id, int val);
    rif.ROB_alu_valid = 1'b1;
    rif.ROB_alu_id    = rob_id_t'(id);
    rif.ROB_alu_value = reg_data_t'(val);
  endtask

  task automatic set_mul(int id, int val);
    rif.ROB_mul_valid = 1'b1;
    rif.ROB_mul_id    = rob_id_t'(id);
    rif.ROB_mul_value = reg_data_t'(val);
  endtask

  task automatic check_model();
    bit c;
    c = mq.size() > 0 && mq[0].done;
    chk("m_we", 32'(rif.ROB_We),
        32'(c && mq[0].w && !rif.ROB_flush));
    chk("m_wat", 32'(rif.ROB_Wat), c ? mq[0].dest : 0);
    chk("m_wvalue", rif.ROB_Wvalue, c ? mq[0].value : 0);
    chk("m_count", 32'(rif.ROB_count), mq.size());
    chk("m_stall", 32'(rif.ROB_stall), 32'(mq.size() == DEPTH));
    chk("m_head", 32'(rif.ROB_head), mhead);
  endtask

  // apply one clock edge to the program-order queue
  task automatic model_step();
    bit    c;
    int    n;
    int    tail;
    ment_t e;
    if (!reset) begin
      mq.delete();
      mhead = 0;
      return;
    end
    n    = mq.size();
    tail = (mhead + n) % DEPTH;
    if (rif.ROB_flush) begin
      mhead = tail;
      mq.delete();
      return;
    end
    c = n > 0 && mq[0].done;
    for (int k = 0; k < n; k++) begin
      e = mq[k];
      if (rif.ROB_mul_valid && e.id == int'(rif.ROB_mul_id)) begin
        e.value = int'(rif.ROB_mul_value);
        e.done  = 1'b1;
      end
      if (rif.ROB_alu_valid && e.id == int'(rif.ROB_alu_id)) begin
        e.value = int'(rif.ROB_alu_value);
        e.done  = 1'b1;
      end
      mq[k] = e;
    end
    if (c) begin
      void'(mq.pop_front());
      mhead = (mhead + 1) % DEPTH;
    end
    if (rif.ROB_alloc && n < DEPTH) begin
      e.id    = tail;
      e.w     = rif.ROB_alloc_w;
      e.dest  = int'(rif.ROB_alloc_dest);
      e.value = 0;
      e.done  = rif.ROB_alloc_done;
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic hchk(string tag, int we, int wat, int wv,
                      int cnt, int hd);
    chk({tag, "_we"}, 32'(rif.ROB_We), we);
    chk({tag, "_wat"}, 32'(rif.ROB_Wat), wat);
    chk({tag, "_wvalue"}, rif.ROB_Wvalue, wv);
    chk({tag, "_count"}, 32'(rif.ROB_count), cnt);
    chk({tag, "_head"}, 32'(rif.ROB_head), hd);
  endtask

  initial begin
    // in-order commit, then a no-write complete-at-alloc entry
    tbl[0] = '{1,0,3,1,0, 0,0,0, 0,0,0, 0,0,0,0,0};
    tbl[1] = '{1,1,4,1,0, 0,0,0, 0,0,0, 0,0,0,1,0};
    tbl[2] = '{0,0,0,0,0, 0,0,0, 1,1,'h22, 0,0,0,2,0};
    tbl[3] = '{0,0,0,0,0, 1,0,'h11, 0,0,0, 0,0,0,2,0};
    tbl[4] = '{0,0,0,0,0, 0,0,0, 0,0,0, 1,3,'h11,2,0};
    tbl[5] = '{0,0,0,0,0, 0,0,0, 0,0,0, 1,4,'h22,1,1};
    tbl[6] = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,2};
    tbl[7] = '{1,2,7,0,1, 0,0,0, 0,0,0, 0,0,0,0,2};
    tbl[8] = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,7,0,1,2};
    tbl[9] = '{0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,3};

    reset = 1'b0;
    idle();
    for (int i = 0; i < 5; i++) begin
      rif.ROB_alloc      = 1'($urandom);
      rif.ROB_alloc_id   = rob_id_t'($urandom);
      rif.ROB_alloc_dest = reg_addr_t'($urandom);
      rif.ROB_alloc_w    = 1'($urandom);
      rif.ROB_alloc_done = 1'($urandom);
      set_alu(int'(rob_id_t'($urandom)), int'($urandom));
      set_mul(int'(rob_id_t'($urandom)), int'($urandom));
      #1;
      hchk("rst", 0, 0, 0, 0, 0);
      chk("rst_stall", 32'(rif.ROB_stall), 0);
      tick();
    end
    idle();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      hchk("rel", 0, 0, 0, 0, 0);
      tick();
    end

    for (int i = 0; i < 10; i++) begin
      idle();
      if (tbl[i].al)
        set_alloc(tbl[i].id, tbl[i].dest, tbl[i].w, tbl[i].dn);
      if (tbl[i].av) set_alu(tbl[i].aid, tbl[i].aval);
      if (tbl[i].mv) set_mul(tbl[i].mid, tbl[i].mval);
      #1;
      hchk($sformatf("tbl%0d", i), tbl[i].we, tbl[i].wat,
           tbl[i].wv, tbl[i].cnt, tbl[i].hd);
      chk($sformatf("tbl%0d_stall", i), 32'(rif.ROB_stall), 0);
      tick();
    end

    // fill from head=3, wrap, stall release, same-edge cases
    for (int k = 0; k < 4; k++) begin
      idle();
      set_alloc((3 + k) % 4, 10 + k, 1'b1, 1'b0);
      #1;
      chk("fill_count", 32'(rif.ROB_count), k);
      chk("fill_stall", 32'(rif.ROB_stall), 0);
      tick();
    end
    idle(); set_alu(3, 'h100); set_mul(0, 'h101); #1;
    chk("full_stall", 32'(rif.ROB_stall), 1);
    hchk("full", 0, 0, 0, 4, 3);
    tick();
    idle(); set_alu(1, 'h102); set_mul(2, 'h103); #1;
    chk("c1_stall", 32'(rif.ROB_stall), 1);
    hchk("c1", 1, 10, 'h100, 4, 3);
    tick();
    idle(); #1;
    chk("c2_stall", 32'(rif.ROB_stall), 0);
    hchk("c2", 1, 11, 'h101, 3, 0);
    tick();
    idle(); set_alloc(3, 20, 1'b1, 1'b0); #1;
    hchk("ac", 1, 12, 'h102, 2, 1);
    tick();
    idle(); set_alu(3, 'h33); #1;
    hchk("ac2", 1, 13, 'h103, 2, 2);
    tick();
    idle(); #1;
    hchk("c5", 1, 20, 'h33, 1, 3);
    tick();
    idle(); #1;
    hchk("c6", 0, 0, 0, 0, 0);
    tick();

    // flush with id1 done, then a stale result for id1
    idle(); set_alloc(0, 5, 1'b1, 1'b0); tick();
    idle(); set_alloc(1, 6, 1'b1, 1'b0); tick();
    idle(); set_alloc(2, 7, 1'b1, 1'b0); set_alu(1, 'h55); tick();
    idle(); rif.ROB_flush = 1'b1; #1;
    hchk("fl", 0, 0, 0, 3, 0);
    tick();
    idle(); set_alu(1, 'h77); #1;
    hchk("fl1", 0, 0, 0, 0, 3);
    tick();
    idle(); #1;
    hchk("fl2", 0, 0, 0, 0, 3);
    tick();

    for (int cyc = 0; cyc < 600; cyc++) begin
      int n;
      int aid;
      int mid;
      n = mq.size();
      idle();
      rif.ROB_flush = ($urandom_range(0, 19) == 0);
      if (!rif.ROB_flush && n < DEPTH && $urandom_range(0, 2) != 0)
        set_alloc((mhead + n) % DEPTH, int'($urandom_range(0, 31)),
                  1'($urandom), $urandom_range(0, 3) == 0);
      aid = $urandom_range(0, DEPTH - 1);
      mid = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 1) != 0) set_alu(aid, int'($urandom));
      if ($urandom_range(0, 1) != 0
          && !(rif.ROB_alu_valid && mid == aid))
        set_mul(mid, int'($urandom));
      tick();
    end

    // asynchronous reset with entries in flight
    idle(); rif.ROB_flush = 1'b1; tick();
    idle(); set_alloc(mhead, 9, 1'b1, 1'b1); tick();
    idle(); set_alloc((mhead + 1) % DEPTH, 8, 1'b1, 1'b0); tick();
    idle();
    reset = 1'b0;
    #1;
    hchk("async_rst", 0, 0, 0, 0, 0);
    chk("async_rst_stall", 32'(rif.ROB_stall), 0);
    mq.delete();
    mhead = 0;
    tick();
    reset = 1'b1;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
